line_queue_scheduler: RTL and testbench

Circular work queue and pass controller that sequences the nonogram solver. It holds the line headers and option words for every row and column line. It presents them to the solver one word at a time and re-enqueues the words the solver puts back. It also decides when solving ends: on `solved`, on a full pass over all lines with no progress, or on queue overflow.

---
 rtl/line_queue_scheduler.sv | 162 ++++++++++++++++
 tb/tb_line_queue_scheduler.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/line_queue_scheduler.sv
// line_queue_scheduler
// Circular work queue plus pass controller for the nonogram solver. Holds the
// line headers and option words, presents them one at a time with a
// first-word-fall-through head, re-enqueues words the solver pushes back, and
// decides when solving ends (solved, a full pass without progress, or overflow).
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   num_rows, num_cols        active board size (stable outside IDLE)
//   load_valid/header/data    parser load port, load_ready accepts
//   load_done                 parser finished; enters RUN, pulses started
//   head_valid/header/data    queue head to the solver
//   advance                   consume the head
//   requeue_valid/header/data push a word back to the tail (RUN only)
//   progress, solved          solver status for the pass controller
//   flush                     synchronous return to IDLE
//   busy, stalled, overflow   status; stalled/overflow are sticky
//   occupancy                 entries currently held
module line_queue_scheduler #(
  parameter int unsigned MAX_ROWS = 11,
  parameter int unsigned MAX_COLS = 11,
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned DEPTH    = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [$clog2(MAX_ROWS)-1:0]  num_rows,
  input  logic [$clog2(MAX_COLS)-1:0]  num_cols,
  input  logic                         load_valid,
  input  logic                         load_header,
  input  logic [WIDTH-1:0]             load_data,
  output logic                         load_ready,
  input  logic                         load_done,
  output logic                         started,
  output logic                         head_valid,
  output logic                         head_header,
  output logic [WIDTH-1:0]             head_data,
  input  logic                         advance,
  input  logic                         requeue_valid,
  input  logic                         requeue_header,
  input  logic [WIDTH-1:0]             requeue_data,
  input  logic                         progress,
  input  logic                         solved,
  input  logic                         flush,
  output logic                         busy,
  output logic                         stalled,
  output logic                         overflow,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned OW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(MAX_ROWS + MAX_COLS + 1);

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

  state_e          state_q;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [OW-1:0]   count_q;
  logic [PW-1:0]   pass_cnt_q;
  logic [WIDTH:0]  mem [DEPTH];

  logic            full;
  logic            load_push, req_push, push_ok, pop, ovf_evt, hdr_pop;
  logic [WIDTH:0]  push_word;
  logic [PW-1:0]   limit, pass_inc, pass_nxt;

  always_comb begin
    full        = (count_q == OW'(DEPTH));
    load_ready  = (state_q == StIdle) || ((state_q == StLoad) && !full);
    head_valid  = (state_q == StRun) && (count_q != '0);
    head_header = mem[rd_ptr_q][WIDTH];
    head_data   = mem[rd_ptr_q][WIDTH-1:0];
    busy        = (state_q == StLoad) || (state_q == StRun);
    occupancy   = count_q;

    load_push = load_valid && load_ready;
    req_push  = (state_q == StRun) && requeue_valid;
    pop       = head_valid && advance;
    // At full, a same-cycle pop frees the slot the push writes.
    push_ok   = load_push || (req_push && (!full || pop));
    ovf_evt   = req_push && full && !pop;
    push_word = (state_q == StRun) ? {requeue_header, requeue_data}
                                   : {load_header, load_data};
    hdr_pop   = pop && head_header;

    limit    = PW'(num_rows) + PW'(num_cols);
    pass_inc = (pass_cnt_q >= limit) ? limit : PW'(pass_cnt_q + 1'b1);
    if (progress) begin
      pass_nxt = '0;
    end else if (hdr_pop) begin
      pass_nxt = pass_inc;
    end else begin
      pass_nxt = pass_cnt_q;
    end
  end

  // Storage is not reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok && !flush && !rst) begin
      mem[wr_ptr_q] <= push_word;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      pass_cnt_q <= '0;
      started    <= 1'b0;
      stalled    <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      started <= 1'b0;
      if (flush) begin
        state_q    <= StIdle;
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
        count_q    <= '0;
        pass_cnt_q <= '0;
        stalled    <= 1'b0;
        overflow   <= 1'b0;
      end else begin
        if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
        count_q <= count_q + OW'(push_ok) - OW'(pop);

        unique case (state_q)
          StIdle: begin
            if (load_push) state_q <= StLoad;
          end
          StLoad: begin
            if (load_done) begin
              state_q    <= StRun;
              started    <= 1'b1;
              pass_cnt_q <= '0;
            end
          end
          StRun: begin
            pass_cnt_q <= pass_nxt;
            if (solved) begin
              state_q <= StDone;
            end else if (ovf_evt) begin
              overflow <= 1'b1;
              state_q  <= StDone;
            end else if ((count_q == '0) || (pass_nxt >= limit)) begin
              stalled <= 1'b1;
              state_q <= StDone;
            end
          end
          StDone: begin
            state_q <= StDone;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_line_queue_scheduler.sv
module tb_line_queue_scheduler;
  localparam int unsigned MR = 11;
  localparam int unsigned MC = 11;
  localparam int unsigned W  = 16;
  localparam int unsigned D  = 8;
  localparam int unsigned OW = $clog2(D + 1);

  logic          clk, rst;
  logic [3:0]    num_rows, num_cols;
  logic          load_valid, load_header, load_ready, load_done, started;
  logic [W-1:0]  load_data;
  logic          head_valid, head_header;
  logic [W-1:0]  head_data;
  logic          advance, requeue_valid, requeue_header;
  logic [W-1:0]  requeue_data;
  logic          progress, solved, flush, busy, stalled, overflow;
  logic [OW-1:0] occupancy;

  line_queue_scheduler #(.MAX_ROWS(MR), .MAX_COLS(MC), .WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .num_rows(num_rows), .num_cols(num_cols),
    .load_valid(load_valid), .load_header(load_header), .load_data(load_data),
    .load_ready(load_ready), .load_done(load_done), .started(started),
    .head_valid(head_valid), .head_header(head_header), .head_data(head_data),
    .advance(advance), .requeue_valid(requeue_valid), .requeue_header(requeue_header),
    .requeue_data(requeue_data), .progress(progress), .solved(solved), .flush(flush),
    .busy(busy), .stalled(stalled), .overflow(overflow), .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a plain queue of tagged words plus mode flags.
  typedef enum {MIdle, MLoad, MRun, MDone} mode_t;
  mode_t        m_mode;
  logic [W:0]   m_q[$];
  int           m_pass;
  bit           m_stalled, m_ovf, m_started;

  task automatic model_reset();
    m_mode = MIdle; m_q.delete(); m_pass = 0;
    m_stalled = 0; m_ovf = 0; m_started = 0;
  endtask

  task automatic check_outputs();
    bit hv;
    hv = (m_mode == MRun) && (m_q.size() > 0);
    check_eq("load_ready", load_ready,
             (m_mode == MIdle) || (m_mode == MLoad && m_q.size() < D));
    check_eq("head_valid", head_valid, hv);
    if (hv) begin
      check_eq("head_header", head_header, m_q[0][W]);
      check_eq("head_data", head_data, m_q[0][W-1:0]);
    end
    check_eq("busy", busy, (m_mode == MLoad) || (m_mode == MRun));
    check_eq("stalled", stalled, m_stalled);
    check_eq("overflow", overflow, m_ovf);
    check_eq("occupancy", occupancy, m_q.size());
    check_eq("started", started, m_started);
  endtask

  task automatic model_step();
    int  limit;
    bit  pop, hdr, drop;
    limit = int'(num_rows) + int'(num_cols);
    m_started = 0;
    if (flush) begin
      model_reset();
      return;
    end
    case (m_mode)
      MIdle: if (load_valid) begin
        m_q.push_back({load_header, load_data});
        m_mode = MLoad;
      end
      MLoad: begin
        if (load_valid && m_q.size() < D) m_q.push_back({load_header, load_data});
        if (load_done) begin
          m_mode = MRun; m_started = 1; m_pass = 0;
        end
      end
      MRun: begin
        pop  = advance && m_q.size() > 0;
        hdr  = pop && m_q[0][W];
        drop = requeue_valid && m_q.size() == D && !pop;
        if (progress) m_pass = 0;
        else if (hdr) m_pass = (m_pass + 1 > limit) ? limit : m_pass + 1;
        if (solved) m_mode = MDone;
        else if (drop) begin m_ovf = 1; m_mode = MDone; end
        else if (m_q.size() == 0 || m_pass >= limit) begin m_stalled = 1; m_mode = MDone; end
        if (pop) void'(m_q.pop_front());
        if (requeue_valid && !drop) m_q.push_back({requeue_header, requeue_data});
      end
      default: ;
    endcase
  endtask

  task automatic tick();
    #1;
    check_outputs();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit lv, input bit lh, input logic [W-1:0] ld, input bit ldone,
                       input bit adv, input bit rv, input bit rh, input logic [W-1:0] rd,
                       input bit prog, input bit solv, input bit fl);
    load_valid = lv; load_header = lh; load_data = ld; load_done = ldone;
    advance = adv; requeue_valid = rv; requeue_header = rh; requeue_data = rd;
    progress = prog; solved = solv; flush = fl;
    tick();
  endtask

  task automatic nop();
    drive(0, 0, '0, 0, 0, 0, 0, '0, 0, 0, 0);
  endtask

  task automatic do_flush();
    drive(0, 0, '0, 0, 0, 0, 0, '0, 0, 0, 1);
  endtask

  task automatic load_word(input bit h, input logic [W-1:0] d);
    drive(1, h, d, 0, 0, 0, 0, '0, 0, 0, 0);
  endtask

  task automatic finish_load();
    drive(0, 0, '0, 1, 0, 0, 0, '0, 0, 0, 0);
  endtask

  initial begin
    logic [W:0] w;
    rst = 1'b1;
    num_rows = 4'd1; num_cols = 4'd1;
    load_valid = 0; load_header = 0; load_data = '0; load_done = 0;
    advance = 0; requeue_valid = 0; requeue_header = 0; requeue_data = '0;
    progress = 0; solved = 0; flush = 0;
    model_reset();
    @(posedge clk); #1;
    check_outputs();
    @(posedge clk); #1;
    rst = 1'b0;

    // H0,A,B,H1,C; each popped word is requeued, so A lands after C.
    load_word(1, 16'h0000); load_word(0, 16'h00AA); load_word(0, 16'h00BB);
    load_word(1, 16'h0001); load_word(0, 16'h00CC);
    finish_load();
    for (int i = 0; i < 8 && m_mode == MRun; i++) begin
      w = m_q[0];
      drive(0, 0, '0, 0, 1, 1, w[W], w[W-1:0], i == 1, 0, 0);
    end
    nop();
    do_flush();

    // Fill past depth, then full-queue advance+requeue, then overflow.
    num_rows = 4'd10; num_cols = 4'd10;
    for (int i = 0; i < 10; i++) load_word(0, W'(16'h100 + i));
    finish_load();
    for (int i = 0; i < 6; i++) drive(0, 0, '0, 0, 1, 1, 0, W'(16'h200 + i), 0, 0, 0);
    drive(0, 0, '0, 0, 0, 1, 0, 16'hDEAD, 0, 0, 0);
    nop(); nop();
    do_flush();

    // Pass stall with 2+2 lines, then a repeat with progress on the 3rd header.
    num_rows = 4'd2; num_cols = 4'd2;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 8; i++) load_word(1, W'(i));
      finish_load();
      for (int i = 0; i < 8 && m_mode == MRun; i++)
        drive(0, 0, '0, 0, 1, 0, 0, '0, (r == 1) && (i == 2), 0, 0);
      nop();
      do_flush();
    end

    // solved + progress on a stall-triggering header.
    num_rows = 4'd1; num_cols = 4'd1;
    load_word(1, 16'h0); load_word(1, 16'h1); load_word(0, 16'h5);
    finish_load();
    drive(0, 0, '0, 0, 1, 0, 0, '0, 0, 0, 0);
    drive(0, 0, '0, 0, 1, 0, 0, '0, 1, 1, 0);
    nop();
    do_flush();

    // Asynchronous reset mid-RUN at occupancy 5, then reload.
    num_rows = 4'd3; num_cols = 4'd3;
    for (int i = 0; i < 5; i++) load_word(0, W'(16'h300 + i));
    finish_load();
    nop();
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    @(posedge clk); #1;
    check_outputs();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) load_word(i == 0, W'(16'h400 + i));
    finish_load();
    for (int i = 0; i < 6 && m_mode == MRun; i++) drive(0, 0, '0, 0, 1, 1, 0, 16'h7, 0, 0, 0);
    do_flush();

    // Randomized episodes.
    for (int e = 0; e < 60; e++) begin
      int n;
      num_rows = 4'($urandom_range(1, 3));
      num_cols = 4'($urandom_range(1, 3));
      n = $urandom_range(1, 11);
      for (int i = 0; i < n; i++)
        drive($urandom % 4 != 0, $urandom % 3 == 0, W'($urandom), 0,
              0, 0, 0, '0, 0, 0, 0);
      finish_load();
      for (int c = 0; c < 40 && m_mode == MRun; c++)
        drive(0, 0, '0, 0, $urandom % 4 != 0, $urandom % 2 == 0, $urandom % 3 == 0,
              W'($urandom), $urandom % 8 == 0, $urandom % 50 == 0, $urandom % 100 == 0);
      drive(0, 0, '0, 0, 1, 1, 0, 16'h1, 0, 0, 0);
      nop();
      do_flush();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule
